// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: stage/forward codes, default MDU latencies and the tracker entry shared by hazard_ctrl and hazard_mdu_timer
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {ST_DECODE = 2'd0, ST_EXECUTE = 2'd1, ST_MEM = 2'd2, ST_MAX = 2'd3} stage_e;
  typedef enum logic [1:0] {FWD_NONE = 2'd0, FWD_E = 2'd1, FWD_M = 2'd2, FWD_W = 2'd3} fwd_e;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;
  typedef struct packed {
    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] wa;
    logic [1:0] ws;
  } entry_t;
  // True when the nearest producer of a (searching E, M, W) cannot deliver by read stage rs.
  function automatic logic blocked(entry_t e, entry_t m, entry_t w, logic [4:0] a, logic [1:0] rs);
    entry_t [3:1] t;
    logic b;
    t = {w, m, e};
    b = 1'b0;
    for (int i = 3; i >= 1; i--)
      if (t[i].wa == a && a != '0) b = rs != ST_MAX && int'(t[i].ws) >= i + int'(rs);
    return b;
  endfunction
  // Nearest producer of a among stages lo..3; forward codes equal stage indices, so the code is the stage number.
  function automatic logic [1:0] fwd_src(entry_t e, entry_t m, entry_t w, logic [4:0] a, int lo);
    entry_t [3:1] t;
    logic [1:0] s;
    t = {w, m, e};
    s = FWD_NONE;
    for (int i = 3; i >= 1; i--)
      if (i >= lo && t[i].wa == a && a != '0) s = int'(t[i].ws) < i ? 2'(i) : FWD_NONE;
    return s;
  endfunction
endpackage

// File: rtl/hazard_mdu_timer.sv
// hazard_mdu_timer: MDU busy counter; load/is_div start a multiply or divide latency, busy while nonzero (clk, rst_n async low)
module hazard_mdu_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic is_div,
  output logic busy
);
  localparam int MAXC = DIV_CYCLES > MULT_CYCLES ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? (is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : cnt - CW'(cnt != '0);
  assign busy = cnt != '0;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/forward control from an E/M/W tracker of decoded read/write intents.
// Ports: clk, rst_n (async low); d_read_addr0/1, d_read_stage0/1, d_write_addr, d_write_stage from decode;
// stall, fwd_d0/1 (decode readers), fwd_e0/1 (execute readers), fwd_m1 (store data).
// Macro HAZARD_MDU_EN adds d_mdu_start, d_mdu_is_div, d_mdu_use and mdu_busy for multiply/divide interlock.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef HAZARD_MDU_EN
  input  logic       d_mdu_start,
  input  logic       d_mdu_is_div,
  input  logic       d_mdu_use,
  output logic       mdu_busy,
`endif
  input  logic [4:0] d_read_addr0,
  input  logic [4:0] d_read_addr1,
  input  logic [1:0] d_read_stage0,
  input  logic [1:0] d_read_stage1,
  input  logic [4:0] d_write_addr,
  input  logic [1:0] d_write_stage,
  output logic       stall,
  output logic [1:0] fwd_d0,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_e0,
  output logic [1:0] fwd_e1,
  output logic [1:0] fwd_m1
);
  entry_t e, m, w;
  logic mdu_stall;
  if (MULT_CYCLES < 1 || DIV_CYCLES < 1) begin : g_bad_latency
    $error("hazard_ctrl: MDU latencies must be at least 1");
  end
`ifdef HAZARD_MDU_EN
  hazard_mdu_timer #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (d_mdu_start & ~stall),
    .is_div(d_mdu_is_div),
    .busy  (mdu_busy)
  );
  assign mdu_stall = d_mdu_use & mdu_busy;
`else
  assign mdu_stall = 1'b0;
`endif
  assign stall = blocked(e, m, w, d_read_addr0, d_read_stage0)
               | blocked(e, m, w, d_read_addr1, d_read_stage1) | mdu_stall;
  assign fwd_d0 = fwd_src(e, m, w, d_read_addr0, 1);
  assign fwd_d1 = fwd_src(e, m, w, d_read_addr1, 1);
  assign fwd_e0 = fwd_src(e, m, w, e.rd0, 2);
  assign fwd_e1 = fwd_src(e, m, w, e.rd1, 2);
  assign fwd_m1 = fwd_src(e, m, w, m.rd1, 3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      e <= '0;
      m <= '0;
      w <= '0;
    end else begin
      w <= m;
      m <= e;
      e <= stall ? '0 : {d_read_addr0, d_read_addr1, d_write_addr, d_write_stage};
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, 5, MDU busy cycles after a multiply issues.
REQ-002 Parameter DIV_CYCLES, 10, MDU busy cycles after a divide issues.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 d_read_addr0 / d_read_addr1  in  5  rs/rt of instruction in decode.
REQ-006 d_read_stage0 / d_read_stage1  in  2  stage each operand is first needed (DECODE=0, EXECUTE=1, MEM=2, MAX=3 never).
REQ-007 d_write_addr  in  5  destination of decode instruction; 0 = no write.
REQ-008 d_write_stage  in  2  stage whose end produces the result.
REQ-009 stall  out  1  freeze PC and F/D register, inject bubble into E.
REQ-010 fwd_d0 / fwd_d1  out  2  operand source for decode-stage readers (NONE=0, E=1, M=2, W=3).
REQ-011 fwd_e0 / fwd_e1  out  2  operand source for execute-stage readers (NONE, M, W only).
REQ-012 fwd_m1  out  2  rt source for memory-stage store data (NONE, W only).

Function
REQ-013 Tracker holds entries E, M, W, each {rd0, rd1, wa, ws}; bubble = all fields 0.
REQ-014 Each edge: W<=M, M<=E; E<=decode fields when stall=0, else bubble.
REQ-015 Producer at stage X (E=1, M=2, W=3) blocks operand i iff wa==addr_i, addr_i!=0, read_stage_i!=MAX, and ws >= X + read_stage_i.
REQ-016 Only the nearest matching producer (E before M before W) is evaluated per operand.
REQ-017 stall is combinational, same cycle, OR of both operand blocks (plus REQ-027 when enabled).
REQ-018 Forward source = nearest newer entry with wa==consumer addr, addr!=0, and ws < its stage index; else NONE.
REQ-019 Decode readers consider E, M, W; execute readers M, W; memory readers W only.
REQ-020 Nearest matching producer not yet available yields NONE, never an older entry.
REQ-021 Writes to register 0 never stall and never forward.
REQ-022 A stalled decode instruction keeps stalling until REQ-015 clears; no cycle limit.

Reset
REQ-023 rst_n low clears all tracker entries to bubble immediately, independent of clk.
REQ-024 During and right after reset: stall=0 and all fwd outputs NONE.
REQ-025 Reset mid-operation discards in-flight hazards; first post-reset decode sees an empty pipeline.

Configuration
REQ-026 Macro HAZARD_MDU_EN adds inputs d_mdu_start (1), d_mdu_is_div (1), d_mdu_use (1) and output mdu_busy (1).
REQ-027 With the macro, stall also asserts when d_mdu_use=1 and the MDU counter is nonzero.
REQ-028 Counter loads DIV_CYCLES or MULT_CYCLES when a d_mdu_start instruction advances into E.
REQ-029 Counter otherwise decrements to 0 and saturates; async reset clears it; mdu_busy = counter!=0.
REQ-030 Without the macro, none of these ports exist and MDU logic is absent.

Structure
REQ-031 Shared package holds stage codes, forward codes and default MDU latencies.
REQ-032 Sub-module hazard_mdu_timer holds the counter; it is instantiated only under HAZARD_MDU_EN.

Verification
REQ-033 lw $1 (ws=2), then addu rs=$1 (rs=1): stall=1 for one cycle; next cycle fwd_e0=W.
REQ-034 addu $2 (ws=1), then beq rs=$2 (rs=0): stall=1 for one cycle; next cycle fwd_d0=M.
REQ-035 jal (wa=31, ws=0), then jr $31: no stall; fwd_d0=E.
REQ-036 addu $0 (wa=0), then addu rs=$0: stall=0, all fwd NONE.
REQ-037 lw $3, then sw rt=$3 (rt stage=2): no stall; fwd_m1=W when sw reaches M.
REQ-038 HAZARD_MDU_EN: div issues, mfhi follows: stall=1 for 10 cycles; async reset mid-count clears stall and mdu_busy.
